// File: rtl/timestamp_generator_multi.sv
// Prescaled free-running timestamp counter with per-channel single-slot event capture.
// Define TIMESTAMP_GENERATOR_GRAY_EN to add a registered Gray-coded copy of the timestamp.

module ts_cap_lane #(
    parameter int TS_WIDTH = 64
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [TS_WIDTH-1:0] ts,
    input  logic                ev,
    input  logic                ready,
    input  logic                ovf_clr,
    output logic                valid,
    output logic [TS_WIDTH-1:0] cap,
    output logic                ovf
);
    logic take;
    logic drop;

    // Slot accepts a new capture if empty or being drained this cycle.
    assign take = ev && (!valid || ready);
    assign drop = ev && valid && !ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            valid <= 1'b0;
            cap   <= '0;
            ovf   <= 1'b0;
        end else begin
            if (take) begin
                cap   <= ts;
                valid <= 1'b1;
            end else if (valid && ready) begin
                valid <= 1'b0;
            end
            if (drop)
                ovf <= 1'b1;
            else if (ovf_clr)
                ovf <= 1'b0;
        end
    end
endmodule

module timestamp_generator_multi #(
    parameter int TS_WIDTH       = 64,
    parameter int PRESCALE_WIDTH = 16,
    parameter int NUM_CH         = 4
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         run,
    input  logic [PRESCALE_WIDTH-1:0]    prescale,
    input  logic                         load,
    input  logic [TS_WIDTH-1:0]          load_value,
    output logic [TS_WIDTH-1:0]          timestamp,
    output logic                         tick,
    output logic                         wrap,
    input  logic [NUM_CH-1:0]            ch_event,
    output logic [NUM_CH-1:0]            cap_valid,
    input  logic [NUM_CH-1:0]            cap_ready,
    output logic [NUM_CH*TS_WIDTH-1:0]   cap_ts,
    output logic [NUM_CH-1:0]            cap_overflow,
`ifdef TIMESTAMP_GENERATOR_GRAY_EN
    output logic [TS_WIDTH-1:0]          timestamp_gray,
`endif
    input  logic                         overflow_clear
);
    logic [PRESCALE_WIDTH-1:0] pc, pc_nxt;
    logic [TS_WIDTH-1:0]       ts_nxt;
    logic                      tick_nxt, wrap_nxt;

    // >= rather than == so a prescale shrunk below pc rolls over at once.
    always_comb begin
        pc_nxt   = pc;
        ts_nxt   = timestamp;
        tick_nxt = 1'b0;
        wrap_nxt = 1'b0;
        if (load) begin
            pc_nxt = '0;
            ts_nxt = load_value;
        end else if (run) begin
            if (pc >= prescale) begin
                pc_nxt   = '0;
                ts_nxt   = timestamp + TS_WIDTH'(1);
                tick_nxt = 1'b1;
                wrap_nxt = &timestamp;
            end else begin
                pc_nxt = pc + PRESCALE_WIDTH'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc        <= '0;
            timestamp <= '0;
            tick      <= 1'b0;
            wrap      <= 1'b0;
        end else begin
            pc        <= pc_nxt;
            timestamp <= ts_nxt;
            tick      <= tick_nxt;
            wrap      <= wrap_nxt;
        end
    end

`ifdef TIMESTAMP_GENERATOR_GRAY_EN
    always_ff @(posedge clk) begin
        if (reset)
            timestamp_gray <= '0;
        else
            timestamp_gray <= ts_nxt ^ (ts_nxt >> 1);
    end
`endif

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        ts_cap_lane #(.TS_WIDTH(TS_WIDTH)) u_lane (
            .clk     (clk),
            .reset   (reset),
            .ts      (timestamp),
            .ev      (ch_event[i]),
            .ready   (cap_ready[i]),
            .ovf_clr (overflow_clear),
            .valid   (cap_valid[i]),
            .cap     (cap_ts[i*TS_WIDTH +: TS_WIDTH]),
            .ovf     (cap_overflow[i])
        );
    end
endmodule

// File: tb/tb_timestamp_generator_multi.sv
// Bench for timestamp_generator_multi: directed counting/load/wrap checks plus a
// per-channel capture scoreboard drained on each cap_valid/cap_ready handshake.
module tb_timestamp_generator_multi;
    localparam int W  = 64;
    localparam int PW = 16;
    localparam int NC = 4;

    logic            clk = 1'b0;
    logic            reset, run, load, overflow_clear;
    logic [PW-1:0]   prescale;
    logic [W-1:0]    load_value, timestamp;
    logic            tick, wrap;
    logic [NC-1:0]   ch_event, cap_valid, cap_ready, cap_overflow;
    logic [NC*W-1:0] cap_ts;

    logic            r8, run8, l8, oc8, tick8, wrap8;
    logic [PW-1:0]   ps8;
    logic [7:0]      lv8, ts8, cts8;
    logic [0:0]      ev8, cv8, cr8, co8;
`ifdef TIMESTAMP_GENERATOR_GRAY_EN
    logic [W-1:0]    timestamp_gray;
    logic [7:0]      gray8;
`endif

    int checks = 0;
    int errors = 0;
    logic [W-1:0] exp_q [NC][$];

    always #5 clk = ~clk;

    timestamp_generator_multi #(.TS_WIDTH(W), .PRESCALE_WIDTH(PW), .NUM_CH(NC)) u_dut (
        .clk(clk), .reset(reset), .run(run), .prescale(prescale), .load(load),
        .load_value(load_value), .timestamp(timestamp), .tick(tick), .wrap(wrap),
        .ch_event(ch_event), .cap_valid(cap_valid), .cap_ready(cap_ready),
        .cap_ts(cap_ts), .cap_overflow(cap_overflow),
`ifdef TIMESTAMP_GENERATOR_GRAY_EN
        .timestamp_gray(timestamp_gray),
`endif
        .overflow_clear(overflow_clear)
    );

    timestamp_generator_multi #(.TS_WIDTH(8), .PRESCALE_WIDTH(PW), .NUM_CH(1)) u_dut8 (
        .clk(clk), .reset(r8), .run(run8), .prescale(ps8), .load(l8),
        .load_value(lv8), .timestamp(ts8), .tick(tick8), .wrap(wrap8),
        .ch_event(ev8), .cap_valid(cv8), .cap_ready(cr8),
        .cap_ts(cts8), .cap_overflow(co8),
`ifdef TIMESTAMP_GENERATOR_GRAY_EN
        .timestamp_gray(gray8),
`endif
        .overflow_clear(oc8)
    );

    task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic load_ts(input logic [W-1:0] v);
        load = 1'b1; load_value = v;
        step();
        load = 1'b0;
    endtask

    // Handshake about to complete on the next edge: pop and compare.
    always @(negedge clk) begin
        if (!reset) begin
            for (int i = 0; i < NC; i++) begin
                if (cap_valid[i] && cap_ready[i]) begin
                    if (exp_q[i].size() == 0)
                        chk($sformatf("sb_underflow%0d", i), 1, 0);
                    else
                        chk($sformatf("cap_ts%0d", i), cap_ts[i*W +: W], exp_q[i].pop_front());
                end
            end
        end
    end

`ifdef TIMESTAMP_GENERATOR_GRAY_EN
    always @(negedge clk) begin
        chk("gray", timestamp_gray, timestamp ^ (timestamp >> 1));
        chk("gray8", {56'd0, gray8}, {56'd0, ts8 ^ (ts8 >> 1)});
    end
`endif

    initial begin
        #2000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        int nwrap;
        reset = 1; run = 0; load = 0; overflow_clear = 0; prescale = '0;
        load_value = '0; ch_event = '0; cap_ready = '0;
        r8 = 1; run8 = 0; l8 = 0; oc8 = 0; ps8 = '0; lv8 = '0; ev8 = '0; cr8 = '0;
        repeat (3) step();
        chk("rst_ts", timestamp, 0);
        chk("rst_tick", {63'd0, tick}, 0);
        chk("rst_wrap", {63'd0, wrap}, 0);
        chk("rst_valid", {60'd0, cap_valid}, 0);
        chk("rst_ovf", {60'd0, cap_overflow}, 0);

        // prescale 0: one increment per cycle, tick every cycle
        reset = 0; r8 = 0; run = 1; prescale = 0;
        for (int k = 1; k <= 50; k++) begin
            step();
            chk($sformatf("cnt%0d", k), timestamp, k);
            chk($sformatf("tick%0d", k), {63'd0, tick}, 1);
        end
        run = 0;
        step();
        chk("freeze_ts", timestamp, 50);
        chk("freeze_tick", {63'd0, tick}, 0);

        // prescale 3 with run gaps; pc phase must survive run=0
        prescale = 3;
        load_ts(0);
        chk("load0_ts", timestamp, 0);
        chk("load0_tick", {63'd0, tick}, 0);
        run = 1; repeat (20) step();
        chk("ps3_ts", timestamp, 5);
        run = 0; repeat (10) step();
        chk("ps3_hold", timestamp, 5);
        run = 1; repeat (2) step();
        run = 0; repeat (5) step();
        run = 1; step();
        chk("phase_a", timestamp, 5);
        step();
        chk("phase_b", timestamp, 6);
        chk("phase_tick", {63'd0, tick}, 1);

        // shrinking prescale below pc forces an immediate increment
        repeat (2) step();
        chk("pre_shrink", timestamp, 6);
        prescale = 1; step();
        chk("shrink_ts", timestamp, 7);
        chk("shrink_tick", {63'd0, tick}, 1);

        // load beats increment and suppresses tick
        prescale = 0;
        load_ts(100);
        chk("ldpri_ts", timestamp, 100);
        chk("ldpri_tick", {63'd0, tick}, 0);
        run = 0; step();
        chk("ldpri_hold", timestamp, 100);

        // channel 1: fill, overflow, clear, set-wins, drain
        load_ts(10);
        ch_event = 4'b0010; exp_q[1].push_back(10); step(); ch_event = '0;
        chk("c1_valid", {60'd0, cap_valid}, 4'b0010);
        chk("c1_ovf0", {60'd0, cap_overflow}, 0);
        load_ts(15);
        ch_event = 4'b0010; step(); ch_event = '0;
        chk("c1_ovf1", {60'd0, cap_overflow}, 4'b0010);
        chk("c1_keep", cap_ts[1*W +: W], 10);
        chk("c1_valid2", {60'd0, cap_valid}, 4'b0010);
        overflow_clear = 1; step(); overflow_clear = 0;
        chk("c1_clr", {60'd0, cap_overflow}, 0);
        overflow_clear = 1; ch_event = 4'b0010; step();
        overflow_clear = 0; ch_event = '0;
        chk("c1_setwins", {60'd0, cap_overflow}, 4'b0010);
        overflow_clear = 1; step(); overflow_clear = 0;
        cap_ready = 4'b0010; step(); cap_ready = '0;
        chk("c1_drain", {60'd0, cap_valid}, 0);

        // channel 0: accept and new event in the same cycle
        load_ts(20);
        ch_event = 4'b0001; exp_q[0].push_back(20); step(); ch_event = '0;
        load_ts(30);
        ch_event = 4'b0001; cap_ready = 4'b0001; exp_q[0].push_back(30);
        step(); ch_event = '0; cap_ready = '0;
        chk("c0_valid", {60'd0, cap_valid}, 4'b0001);
        chk("c0_ts", cap_ts[0 +: W], 30);
        chk("c0_ovf", {60'd0, cap_overflow}, 0);
        cap_ready = 4'b0001; step(); cap_ready = '0;
        chk("c0_drain", {60'd0, cap_valid}, 0);

        // all channels at once capture the same value
        load_ts(35);
        ch_event = '1;
        for (int i = 0; i < NC; i++) exp_q[i].push_back(35);
        step(); ch_event = '0;
        chk("all_valid", {60'd0, cap_valid}, 4'b1111);
        cap_ready = '1; step(); cap_ready = '0;
        chk("all_drain", {60'd0, cap_valid}, 0);

        // reset while counting with pending captures and an overflow
        load_ts(40);
        run = 1; ch_event = 4'b1100; step();
        ch_event = 4'b0100; step(); ch_event = '0;
        chk("pre_rst_ovf", {60'd0, cap_overflow}, 4'b0100);
        reset = 1; load = 1; load_value = 77; ch_event = '1; step();
        load = 0; ch_event = '0;
        chk("mrst_ts", timestamp, 0);
        chk("mrst_tick", {63'd0, tick}, 0);
        chk("mrst_valid", {60'd0, cap_valid}, 0);
        chk("mrst_capts", (cap_ts == '0) ? 64'd1 : 64'd0, 1);
        chk("mrst_ovf", {60'd0, cap_overflow}, 0);
        reset = 0; step();
        chk("resume_ts", timestamp, 1);
        run = 0;

        // 8-bit wrap
        l8 = 1; lv8 = 8'hFE; step(); l8 = 0;
        chk("w8_load", {56'd0, ts8}, 8'hFE);
        nwrap = 0;
        run8 = 1; step(); nwrap += int'(wrap8);
        chk("w8_ff", {56'd0, ts8}, 8'hFF);
        step(); nwrap += int'(wrap8);
        chk("w8_00", {56'd0, ts8}, 0);
        chk("w8_wrap", {63'd0, wrap8}, 1);
        chk("w8_tick", {63'd0, tick8}, 1);
        run8 = 0; step(); nwrap += int'(wrap8);
        chk("w8_count", nwrap, 1);

        for (int i = 0; i < NC; i++)
            chk($sformatf("sb_empty%0d", i), exp_q[i].size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
